// File: rtl/instr_fetch_if.sv
// ----------------------------------------------------------------------------
// instr_fetch_if
//   Bundles the fetch stage's two bus-side paths:
//     - program-memory read handshake (mem_req/mem_addr out, mem_ack/mem_rdata in)
//     - decode-side instruction line (line_data/read_line/pc out)
//   master : the fetch stage (drives requests and the instruction line)
//   slave  : memory + decode side (drives ack/read data, consumes the line)
// ----------------------------------------------------------------------------
interface instr_fetch_if #(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned DATA_W = 16
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] line_data;
    logic              read_line;
    logic [ADDR_W-1:0] pc;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata,
        output line_data,
        output read_line,
        output pc
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rdata,
        input  line_data,
        input  read_line,
        input  pc
    );
endinterface

// File: rtl/instr_fetch.sv
// ----------------------------------------------------------------------------
// instr_fetch
//   Instruction fetch stage. Owns the program counter, reads instruction words
//   from program memory over a req/ack handshake and hands each word to decode
//   with a one-cycle read_line strobe. Accepts branch redirects, stall and halt
//   from the control unit.
//
// Ports
//   clk           in   rising-edge clock
//   rst           in   asynchronous, active-low reset
//   start         in   pulse: begin fetching at RST_PC (only honoured in IDLE)
//   halt          in   pulse: stop fetching and return to IDLE
//   stall         in   level: decode not ready, hold the pending instruction
//   branch_valid  in   pulse: redirect the fetch address to branch_addr
//   branch_addr   in   redirect target
//   busy          out  1 whenever the stage is not IDLE
//   bus           master side of instr_fetch_if
//                   mem_req/mem_addr   read request, held until mem_ack
//                   mem_ack/mem_rdata  one-cycle read completion
//                   line_data/pc       instruction word and its address
//                   read_line          one-cycle strobe: line_data valid
//
// All outputs come straight from flops. A memory transaction is never
// abandoned: a branch or halt that arrives while a request is outstanding
// parks the stage in DRAIN until the ack, whose data is then dropped.
// ----------------------------------------------------------------------------
module instr_fetch #(
    parameter int unsigned          ADDR_W = 9,
    parameter int unsigned          DATA_W = 16,
    parameter logic [ADDR_W-1:0]    RST_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              halt,
    input  logic              stall,
    input  logic              branch_valid,
    input  logic [ADDR_W-1:0] branch_addr,
    output logic              busy,
    instr_fetch_if.master     bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_DRAIN
    } state_e;

    state_e            state_q,      state_d;
    logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
    logic [ADDR_W-1:0] pc_q,         pc_d;
    logic              mem_req_q,    mem_req_d;
    logic [ADDR_W-1:0] mem_addr_q,   mem_addr_d;
    logic [DATA_W-1:0] line_data_q,  line_data_d;
    logic              read_line_q,  read_line_d;
    logic              halt_pend_q,  halt_pend_d;
    logic              busy_q,       busy_d;

    // Halt request seen either earlier in DRAIN or in the current cycle.
    logic              halt_any;
    // Fetch target after this cycle's branch (if any) is folded in.
    logic [ADDR_W-1:0] target_addr;
    logic [ADDR_W-1:0] pc_next;

    assign halt_any    = halt_pend_q | halt;
    assign target_addr = branch_valid ? branch_addr : fetch_addr_q;
    assign pc_next     = pc_q + 1'b1;

    // ------------------------------------------------------------------
    // State register (and all other flops)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            fetch_addr_q <= RST_PC;
            pc_q         <= RST_PC;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            line_data_q  <= '0;
            read_line_q  <= 1'b0;
            halt_pend_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_addr_q <= fetch_addr_d;
            pc_q         <= pc_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
            line_data_q  <= line_data_d;
            read_line_q  <= read_line_d;
            halt_pend_q  <= halt_pend_d;
            busy_q       <= busy_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // Priority in every busy state: halt, then branch, then normal flow.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (halt)              state_d = bus.mem_ack ? S_IDLE  : S_DRAIN;
                else if (branch_valid) state_d = bus.mem_ack ? S_FETCH : S_DRAIN;
                else if (bus.mem_ack)  state_d = S_ISSUE;
            end
            S_ISSUE: begin
                // read_line_q high means the word is being strobed right now.
                if (halt)              state_d = S_IDLE;
                else if (branch_valid) state_d = S_FETCH;
                else if (read_line_q)  state_d = S_FETCH;
            end
            S_DRAIN: begin
                if (bus.mem_ack) state_d = halt_any ? S_IDLE : S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output / datapath logic
    // read_line is a flop, so the strobe is decided on the edge that enters
    // (or keeps) ISSUE: stall is sampled there and the strobe then appears
    // during the ISSUE cycle itself, never in FETCH/DRAIN/IDLE.
    // ------------------------------------------------------------------
    always_comb begin
        fetch_addr_d = fetch_addr_q;
        pc_d         = pc_q;
        mem_req_d    = mem_req_q;
        mem_addr_d   = mem_addr_q;
        line_data_d  = line_data_q;
        read_line_d  = 1'b0;
        halt_pend_d  = halt_pend_q;

        unique case (state_q)
            S_IDLE: begin
                halt_pend_d = 1'b0;
                if (start) begin
                    fetch_addr_d = RST_PC;
                    mem_req_d    = 1'b1;
                    mem_addr_d   = RST_PC;
                end
            end
            S_FETCH: begin
                if (halt) begin
                    if (bus.mem_ack) mem_req_d   = 1'b0;
                    else             halt_pend_d = 1'b1;
                end else if (branch_valid) begin
                    fetch_addr_d = branch_addr;
                    // Completed transaction: re-request the target at once.
                    // Otherwise the old request stays up until DRAIN sees the ack.
                    if (bus.mem_ack) mem_addr_d = branch_addr;
                end else if (bus.mem_ack) begin
                    line_data_d = bus.mem_rdata;
                    pc_d        = fetch_addr_q;
                    mem_req_d   = 1'b0;
                    read_line_d = ~stall;
                end
            end
            S_ISSUE: begin
                if (halt) begin
                    mem_req_d = 1'b0;
                end else if (branch_valid) begin
                    fetch_addr_d = branch_addr;
                    mem_addr_d   = branch_addr;
                    mem_req_d    = 1'b1;
                end else if (read_line_q) begin
                    fetch_addr_d = pc_next;
                    mem_addr_d   = pc_next;
                    mem_req_d    = 1'b1;
                end else begin
                    read_line_d = ~stall;
                end
            end
            S_DRAIN: begin
                if (halt)         halt_pend_d  = 1'b1;
                if (branch_valid) fetch_addr_d = branch_addr;
                if (bus.mem_ack) begin
                    if (halt_any) begin
                        mem_req_d = 1'b0;
                    end else begin
                        mem_addr_d = target_addr;
                        mem_req_d  = 1'b1;
                    end
                end
            end
            default: begin
                mem_req_d = 1'b0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.line_data = line_data_q;
    assign bus.read_line = read_line_q;
    assign bus.pc        = pc_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_instr_fetch.sv
// ----------------------------------------------------------------------------
// tb_instr_fetch
//   Directed bench for instr_fetch. A memory model answers requests with a
//   programmable latency and ack budget. Expected request addresses and
//   expected (pc, line_data) pairs are queued by the stimulus; a monitor pops
//   and compares on every ack and every read_line strobe, and also watches the
//   handshake rules (request held until ack, address stable, no back-to-back
//   read_line).
// ----------------------------------------------------------------------------
module tb_instr_fetch;
    localparam int unsigned AW = 9;
    localparam int unsigned DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          halt = 1'b0;
    logic          stall = 1'b0;
    logic          branch_valid = 1'b0;
    logic [AW-1:0] branch_addr = '0;
    logic          busy;

    instr_fetch_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    instr_fetch #(.ADDR_W(AW), .DATA_W(DW), .RST_PC(9'h000)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .halt         (halt),
        .stall        (stall),
        .branch_valid (branch_valid),
        .branch_addr  (branch_addr),
        .busy         (busy),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [DW-1:0] data;
    } line_t;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] mem [0:511];
    int ack_budget = 0;
    int mem_lat    = 0;
    int wait_cnt   = 0;

    logic [AW-1:0] exp_addr_q [$];
    line_t         exp_line_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_line(input logic [AW-1:0] p, input logic [DW-1:0] d);
        line_t e;
        e.pc   = p;
        e.data = d;
        exp_line_q.push_back(e);
    endtask

    task automatic wait_rl(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.read_line) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL %s: read_line timeout got 0 expected 1", tag);
        end
    endtask

    task automatic wait_ack(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.mem_ack) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL %s: mem_ack timeout got 0 expected 1", tag);
        end
    endtask

    // Drive a one-cycle branch pulse starting at the current negedge.
    task automatic pulse_branch(input logic [AW-1:0] a);
        branch_addr  = a;
        branch_valid = 1'b1;
        @(negedge clk);
        branch_valid = 1'b0;
    endtask

    // Memory model: acks after mem_lat waiting cycles while budget remains.
    initial begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.mem_ack = 1'b0;
            if (rst && bus.mem_req && ack_budget > 0) begin
                if (wait_cnt >= mem_lat) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = mem[bus.mem_addr];
                    ack_budget--;
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Monitor / scoreboard.
    initial begin
        logic          prev_ok;
        logic          prev_req;
        logic          prev_ack;
        logic          prev_rl;
        logic [AW-1:0] prev_addr;
        line_t         e;
        logic [AW-1:0] ea;
        prev_ok   = 1'b0;
        prev_req  = 1'b0;
        prev_ack  = 1'b0;
        prev_rl   = 1'b0;
        prev_addr = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_ok = 1'b0;
            end else begin
                if (bus.read_line) begin
                    if (exp_line_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_read_line: got pc=0x%0h data=0x%0h expected none",
                                 bus.pc, bus.line_data);
                    end else begin
                        e = exp_line_q.pop_front();
                        check("line_data", 32'(bus.line_data), 32'(e.data));
                        check("line_pc",   32'(bus.pc),        32'(e.pc));
                    end
                end
                if (bus.mem_req && bus.mem_ack) begin
                    if (exp_addr_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_ack_addr: got 0x%0h expected none", bus.mem_addr);
                    end else begin
                        ea = exp_addr_q.pop_front();
                        check("mem_addr_seq", 32'(bus.mem_addr), 32'(ea));
                    end
                end
                if (prev_ok) begin
                    if (prev_rl) check("read_line_consecutive", 32'(bus.read_line), 0);
                    if (prev_req && !prev_ack) begin
                        check("mem_req_held",    32'(bus.mem_req),  1);
                        check("mem_addr_stable", 32'(bus.mem_addr), 32'(prev_addr));
                    end
                end
                prev_ok = 1'b1;
            end
            prev_req  = bus.mem_req;
            prev_ack  = bus.mem_ack;
            prev_rl   = bus.read_line;
            prev_addr = bus.mem_addr;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 16'hC000 | 16'(i);
        mem[0] = 16'h0801;
        mem[1] = 16'h0402;
        mem[2] = 16'h2803;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_mem_req",   32'(bus.mem_req),   0);
        check("rst_mem_addr",  32'(bus.mem_addr),  0);
        check("rst_line_data", 32'(bus.line_data), 0);
        check("rst_read_line", 32'(bus.read_line), 0);
        check("rst_pc",        32'(bus.pc),        0);
        check("rst_busy",      32'(busy),          0);
        rst = 1'b1;
        @(negedge clk);

        // 1: start, two words with single-cycle ack
        exp_addr_q.push_back(9'h000);
        exp_addr_q.push_back(9'h001);
        push_line(9'h000, 16'h0801);
        push_line(9'h001, 16'h0402);
        ack_budget = 2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_rl("t1_first");
        wait_rl("t1_second");
        @(negedge clk);
        check("t1_req_addr2",  32'(bus.mem_req),  1);
        check("t1_mem_addr2",  32'(bus.mem_addr), 'h002);
        check("t1_busy",       32'(busy),         1);

        // 2: stall while holding 0x2803
        stall = 1'b1;
        exp_addr_q.push_back(9'h002);
        ack_budget = 1;
        wait_ack("t2_ack");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t2_stall_rl",   32'(bus.read_line), 0);
            check("t2_stall_data", 32'(bus.line_data), 'h2803);
            check("t2_stall_pc",   32'(bus.pc),        'h002);
        end
        push_line(9'h002, 16'h2803);
        stall = 1'b0;
        wait_rl("t2_release");
        @(negedge clk);
        check("t2_single_pulse", 32'(bus.read_line), 0);
        check("t2_next_req",     32'(bus.mem_req),   1);
        check("t2_next_addr",    32'(bus.mem_addr),  'h003);

        // 3: branch while request at 3 outstanding, ack delayed 3 cycles
        pulse_branch(9'h1F0);
        check("t3_drain_req",  32'(bus.mem_req),  1);
        check("t3_drain_addr", 32'(bus.mem_addr), 'h003);
        exp_addr_q.push_back(9'h003);
        mem_lat    = 3;
        ack_budget = 1;
        wait_ack("t3_ack");
        @(negedge clk);
        check("t3_rl_dropped", 32'(bus.read_line), 0);
        check("t3_new_req",    32'(bus.mem_req),   1);
        check("t3_new_addr",   32'(bus.mem_addr),  'h1F0);

        // 4: branch in ISSUE with stall held -> word never strobed
        mem_lat = 0;
        stall   = 1'b1;
        exp_addr_q.push_back(9'h1F0);
        ack_budget = 1;
        wait_ack("t4_ack");
        @(negedge clk);
        check("t4_held_data", 32'(bus.line_data), 'hC1F0);
        check("t4_held_pc",   32'(bus.pc),        'h1F0);
        pulse_branch(9'h005);
        check("t4_rl",        32'(bus.read_line), 0);
        check("t4_req",       32'(bus.mem_req),   1);
        check("t4_addr",      32'(bus.mem_addr),  'h005);
        stall = 1'b0;

        // 5: PC wrap 0x1FF -> 0x000
        pulse_branch(9'h1FF);
        exp_addr_q.push_back(9'h005);
        exp_addr_q.push_back(9'h1FF);
        exp_addr_q.push_back(9'h000);
        push_line(9'h1FF, 16'hC1FF);
        push_line(9'h000, 16'h0801);
        ack_budget = 3;
        wait_rl("t5_1ff");
        wait_rl("t5_000");
        @(negedge clk);
        check("t5_next_addr", 32'(bus.mem_addr), 'h001);

        // 6: halt with request outstanding -> DRAIN -> IDLE
        halt = 1'b1;
        @(negedge clk);
        halt = 1'b0;
        check("t6_drain_busy", 32'(busy),         1);
        check("t6_drain_req",  32'(bus.mem_req),  1);
        check("t6_drain_addr", 32'(bus.mem_addr), 'h001);
        exp_addr_q.push_back(9'h001);
        mem_lat    = 2;
        ack_budget = 1;
        wait_ack("t6_ack");
        @(negedge clk);
        check("t6_idle_busy", 32'(busy),          0);
        check("t6_idle_req",  32'(bus.mem_req),   0);
        check("t6_idle_rl",   32'(bus.read_line), 0);
        check("t6_hold_data", 32'(bus.line_data), 'h0801);
        check("t6_hold_pc",   32'(bus.pc),        'h000);
        pulse_branch(9'h0AA);
        @(negedge clk);
        check("t6_idle_ignore_branch_busy", 32'(busy),        0);
        check("t6_idle_ignore_branch_req",  32'(bus.mem_req), 0);

        // 7: restart, then asynchronous reset mid-FETCH
        mem_lat = 0;
        exp_addr_q.push_back(9'h000);
        push_line(9'h000, 16'h0801);
        ack_budget = 1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_rl("t7_restart");
        @(negedge clk);
        check("t7_fetch_busy", 32'(busy),         1);
        check("t7_fetch_req",  32'(bus.mem_req),  1);
        check("t7_fetch_addr", 32'(bus.mem_addr), 'h001);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("t7_arst_req",   32'(bus.mem_req),   0);
        check("t7_arst_addr",  32'(bus.mem_addr),  0);
        check("t7_arst_data",  32'(bus.line_data), 0);
        check("t7_arst_rl",    32'(bus.read_line), 0);
        check("t7_arst_pc",    32'(bus.pc),        0);
        check("t7_arst_busy",  32'(busy),          0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        check("addr_queue_empty", 32'(exp_addr_q.size()), 0);
        check("line_queue_empty", 32'(exp_line_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
